// File: rtl/timer_device_pkg.sv
// Shared definitions for the memory-mapped countdown timer: register offsets,
// CTRL bit positions, mode codes and FSM state encoding.
package timer_device_pkg;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;

  localparam int BIT_EN      = 0;
  localparam int BIT_MODE_LO = 1;
  localparam int BIT_MODE_HI = 2;
  localparam int BIT_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  // Modes 10 and 11 fall back to one-shot behaviour.
  function automatic logic is_reload(input logic [3:0] ctrl);
    return ctrl[BIT_MODE_HI:BIT_MODE_LO] == MODE_RELOAD;
  endfunction

endpackage

// File: rtl/timer_device.sv
// Countdown timer responder for one timer slot of the bridge: CTRL/PRESET/COUNT
// registers, a four-state count FSM and a level interrupt.
module timer_device
  import timer_device_pkg::*;
#(
  parameter logic [31:0] CTRL_RESET   = 32'h0,
  parameter logic [31:0] PRESET_RESET = 32'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:2] ADDR,
  input  logic [31:0] DIN,
  input  logic        WE,
  output logic [31:0] DOUT,
  output logic        IRQ
);

  logic [3:0]  ctrl_reg;
  logic [31:0] preset_reg;
  logic [31:0] count_reg;
  logic        irq_flag_reg;
  state_t      state_reg;

  // Upper address bits are decoded by the bridge.
  logic unused_addr;
  assign unused_addr = ^ADDR[31:4];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_reg     <= CTRL_RESET[3:0];
      preset_reg   <= PRESET_RESET;
      count_reg    <= 32'd0;
      irq_flag_reg <= 1'b0;
      state_reg    <= ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (ctrl_reg[BIT_EN]) state_reg <= ST_LOAD;
        end
        ST_LOAD: begin
          count_reg <= preset_reg;
          state_reg <= ST_CNT;
        end
        ST_CNT: begin
          if (!ctrl_reg[BIT_EN]) begin
            state_reg <= ST_IDLE;
          end else if (count_reg > 32'd1) begin
            count_reg <= count_reg - 32'd1;
          end else begin
            count_reg    <= 32'd0;
            irq_flag_reg <= 1'b1;
            state_reg    <= ST_INT;
          end
        end
        ST_INT: begin
          state_reg <= ST_IDLE;
          if (is_reload(ctrl_reg)) irq_flag_reg <= 1'b0;
          else                     ctrl_reg[BIT_EN] <= 1'b0;
        end
        default: state_reg <= ST_IDLE;
      endcase

      // CPU writes come last so they win over any same-edge FSM update.
      if (WE) begin
        case (ADDR[3:2])
          OFF_CTRL: begin
            ctrl_reg     <= DIN[3:0];
            irq_flag_reg <= 1'b0;
          end
          OFF_PRESET: preset_reg <= DIN;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    DOUT = 32'd0;
    case (ADDR[3:2])
      OFF_CTRL:   DOUT = {28'd0, ctrl_reg};
      OFF_PRESET: DOUT = preset_reg;
      OFF_COUNT:  DOUT = count_reg;
      default:    DOUT = 32'd0;
    endcase
  end

  assign IRQ = irq_flag_reg & ctrl_reg[BIT_IM];

endmodule
